// File: rtl/ram_2r1w_init.sv
// rtl/ram_2r1w_init.sv - 2-read/1-write RAM that clears itself after reset, 1-cycle registered reads.
// Define RAM_2R1W_BYPASS_EN to forward same-cycle write data to a read of the same address.
module ram_2r1w_init #(
    parameter int WIDTH  = 3,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              W0_en,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic [WIDTH-1:0]  W0_data,
    input  logic              R0_en,
    input  logic [ADDR_W-1:0] R0_addr,
    output logic [WIDTH-1:0]  R0_data,
    input  logic              R1_en,
    input  logic [ADDR_W-1:0] R1_addr,
    output logic [WIDTH-1:0]  R1_data,
    output logic              init_busy
);

    typedef enum logic {INIT, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] counter;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [WIDTH-1:0]  mem_wd;
    logic [WIDTH-1:0]  r0_next;
    logic [WIDTH-1:0]  r1_next;

    // The clear sweep owns the single write port until READY; user writes are dropped.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = W0_addr;
        mem_wd = W0_data;
        if (state == INIT) begin
            mem_we = 1'b1;
            mem_wa = counter;
            mem_wd = '0;
        end else if (W0_en) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        r0_next = mem[R0_addr];
        r1_next = mem[R1_addr];
`ifdef RAM_2R1W_BYPASS_EN
        if (state == READY && W0_en && W0_addr == R0_addr) r0_next = W0_data;
        if (state == READY && W0_en && W0_addr == R1_addr) r1_next = W0_data;
`endif
    end

    // Array has no reset; gating on reset keeps edges during reset from touching it.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            counter   <= '0;
            init_busy <= 1'b1;
        end else if (state == INIT) begin
            counter <= counter + 1'b1;
            if (counter == ADDR_W'(DEPTH - 1)) begin
                state     <= READY;
                init_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            R0_data <= '0;
            R1_data <= '0;
        end else begin
            if (R0_en) R0_data <= (state == INIT) ? '0 : r0_next;
            if (R1_en) R1_data <= (state == INIT) ? '0 : r1_next;
        end
    end

endmodule

// File: tb/tb_ram_2r1w_init.sv
// tb/tb_ram_2r1w_init.sv - directed table-driven bench for ram_2r1w_init.
module tb_ram_2r1w_init;

`ifdef RAM_2R1W_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       W0_en = 1'b0;
    logic [2:0] W0_addr = '0;
    logic [2:0] W0_data = '0;
    logic       R0_en = 1'b0;
    logic [2:0] R0_addr = '0;
    logic [2:0] R0_data;
    logic       R1_en = 1'b0;
    logic [2:0] R1_addr = '0;
    logic [2:0] R1_data;
    logic       init_busy;

    int n_cmp = 0;
    int n_bad = 0;

    ram_2r1w_init #(.WIDTH(3), .DEPTH(8), .ADDR_W(3)) dut (
        .clock(clock), .reset(reset),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data),
        .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(R0_data),
        .R1_en(R1_en), .R1_addr(R1_addr), .R1_data(R1_data),
        .init_busy(init_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       w_en;
        logic [2:0] w_addr;
        logic [2:0] w_data;
        logic       r0_en;
        logic [2:0] r0_addr;
        logic       r1_en;
        logic [2:0] r1_addr;
        logic [2:0] exp_r0;
        logic [2:0] exp_r1;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        W0_en = 1'b0;
        R0_en = 1'b0;
        R1_en = 1'b0;
    endtask

    task automatic count_sweep(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [2:0] wd,
                                input logic e0, input logic [2:0] a0,
                                input logic e1, input logic [2:0] a1,
                                input logic [2:0] x0, input logic [2:0] x1);
        vec_t v;
        v.w_en = we; v.w_addr = wa; v.w_data = wd;
        v.r0_en = e0; v.r0_addr = a0; v.r1_en = e1; v.r1_addr = a1;
        v.exp_r0 = x0; v.exp_r1 = x1;
        return v;
    endfunction

    initial begin
        int n;

        vecs[0]  = mk(0, 0, 0, 1, 0, 1, 4, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 1, 1, 5, 0, 0);
        vecs[2]  = mk(0, 0, 0, 1, 2, 1, 6, 0, 0);
        vecs[3]  = mk(0, 0, 0, 1, 3, 1, 7, 0, 0);
        vecs[4]  = mk(1, 2, 5, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 1, 2, 1, 2, 5, 5);
        vecs[6]  = mk(1, 4, 1, 0, 0, 0, 0, 5, 5);
        vecs[7]  = mk(1, 4, 6, 1, 4, 0, 0, BYP ? 3'd6 : 3'd1, 5);
        vecs[8]  = mk(0, 0, 0, 1, 4, 1, 4, 6, 6);
        vecs[9]  = mk(1, 1, 7, 0, 0, 0, 0, 6, 6);
        vecs[10] = mk(0, 0, 0, 1, 1, 0, 0, 7, 6);
        vecs[11] = mk(1, 1, 2, 0, 1, 1, 1, 7, BYP ? 3'd2 : 3'd7);
        vecs[12] = mk(0, 0, 0, 1, 1, 1, 1, 2, 2);
        vecs[13] = mk(1, 7, 3, 0, 0, 1, 2, 2, 5);
        vecs[14] = mk(0, 0, 0, 1, 0, 1, 7, 0, 3);

        // Asynchronous reset takes effect without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        chk("reset_r0", int'(R0_data), 0);
        chk("reset_r1", int'(R1_data), 0);
        chk("reset_busy", int'(init_busy), 1);
        step();
        step();

        // Release, with a user write to [0] and reads pending throughout the sweep.
        W0_en = 1'b1; W0_addr = 3'd0; W0_data = 3'd7;
        R0_en = 1'b1; R0_addr = 3'd0;
        R1_en = 1'b1; R1_addr = 3'd3;
        reset = 1'b0;
        count_sweep(n);
        chk("sweep_len", n, 8);
        chk("init_read_r0", int'(R0_data), 0);
        chk("init_read_r1", int'(R1_data), 0);
        idle_inputs();

        for (int i = 0; i < 15; i++) begin
            W0_en = vecs[i].w_en; W0_addr = vecs[i].w_addr; W0_data = vecs[i].w_data;
            R0_en = vecs[i].r0_en; R0_addr = vecs[i].r0_addr;
            R1_en = vecs[i].r1_en; R1_addr = vecs[i].r1_addr;
            step();
            chk($sformatf("vec%0d_r0", i), int'(R0_data), int'(vecs[i].exp_r0));
            chk($sformatf("vec%0d_r1", i), int'(R1_data), int'(vecs[i].exp_r1));
            chk($sformatf("vec%0d_busy", i), int'(init_busy), 0);
        end
        idle_inputs();

        // Reset from READY clears registered outputs immediately.
        reset = 1'b1;
        #1;
        chk("ready_reset_r1", int'(R1_data), 0);
        chk("ready_reset_busy", int'(init_busy), 1);
        step();
        reset = 1'b0;
        repeat (4) step();
        chk("mid_sweep_busy", int'(init_busy), 1);

        // Reset partway through the sweep restarts it from entry 0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_sweep(n);
        chk("restart_sweep_len", n, 8);

        R0_en = 1'b1; R0_addr = 3'd7;
        R1_en = 1'b1; R1_addr = 3'd2;
        step();
        chk("post_reset_r0_7", int'(R0_data), 0);
        chk("post_reset_r1_2", int'(R1_data), 0);
        R0_addr = 3'd4;
        R1_addr = 3'd1;
        step();
        chk("post_reset_r0_4", int'(R0_data), 0);
        chk("post_reset_r1_1", int'(R1_data), 0);
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
